// File: rtl/lr_arbiter_if.sv
// lr_arbiter port bundle: two packet sources, the merged output stream
// and the statistics counters.
interface lr_arbiter_if;
  logic         in0_req;
  logic         in1_req;
  logic         in0_ready;
  logic         in1_ready;
  logic         in0_data_wr;
  logic         in1_data_wr;
  logic [133:0] in0_data;
  logic [133:0] in1_data;
  logic         in0_data_valid;
  logic         in1_data_valid;
  logic         in0_data_valid_wr;
  logic         in1_data_valid_wr;
  logic         out_data_wr;
  logic [133:0] out_data;
  logic         out_data_valid;
  logic         out_data_valid_wr;
  logic [31:0]  port0_pkt_cnt;
  logic [31:0]  port1_pkt_cnt;
  logic [15:0]  abort_cnt;
  logic [15:0]  err_cnt;

  modport slave (
    input  in0_req, in1_req,
    input  in0_data_wr, in1_data_wr,
    input  in0_data, in1_data,
    input  in0_data_valid, in1_data_valid,
    input  in0_data_valid_wr, in1_data_valid_wr,
    output in0_ready, in1_ready,
    output out_data_wr, out_data,
    output out_data_valid, out_data_valid_wr,
    output port0_pkt_cnt, port1_pkt_cnt,
    output abort_cnt, err_cnt
  );

  modport master (
    output in0_req, in1_req,
    output in0_data_wr, in1_data_wr,
    output in0_data, in1_data,
    output in0_data_valid, in1_data_valid,
    output in0_data_valid_wr, in1_data_valid_wr,
    input  in0_ready, in1_ready,
    input  out_data_wr, out_data,
    input  out_data_valid, out_data_valid_wr,
    input  port0_pkt_cnt, port1_pkt_cnt,
    input  abort_cnt, err_cnt
  );
endinterface

// File: rtl/lr_arbiter.sv
// Packet-atomic 2-port arbiter: port 1 priority with starvation guard,
// grant timeout, length watchdog and per-port statistics.
module lr_arbiter #(
  parameter int GRANT_TIMEOUT  = 16,
  parameter int MAX_PKT_CYCLES = 64,
  parameter int P1_MAX_CONSEC  = 4
) (
  input logic         clk,
  input logic         rst,
  lr_arbiter_if.slave bus
);

  localparam int WW = $clog2(GRANT_TIMEOUT + 1);
  localparam int LW = $clog2(MAX_PKT_CYCLES + 1);
  localparam int CW = $clog2(P1_MAX_CONSEC + 1);

  localparam logic [WW-1:0] WAIT_LAST  = WW'(GRANT_TIMEOUT - 1);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_PKT_CYCLES);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(P1_MAX_CONSEC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  logic [1:0]    r_state;
  logic          r_req0;
  logic          r_req1;
  logic          r_rdy0;
  logic          r_rdy1;
  logic          r_gnt;
  logic          r_hold;
  logic [WW-1:0] r_wait;
  logic [LW-1:0] r_len;
  logic [CW-1:0] r_consec;

  logic          r_out_wr;
  logic [133:0]  r_out_data;
  logic          r_out_v;
  logic          r_out_vwr;
  logic [31:0]   r_pkt0;
  logic [31:0]   r_pkt1;
  logic [15:0]   r_abort;
  logic [15:0]   r_err;

  logic          w_g_wr;
  logic [133:0]  w_g_data;
  logic          w_g_v;
  logic          w_g_vwr;
  logic [1:0]    w_g_type;
  logic          w_stray0;
  logic          w_stray1;
  logic          w_proto;
  logic [15:0]   w_err_inc;
  logic [LW-1:0] w_len_nxt;
  logic          w_pick1;

  always_comb begin
    w_g_wr   = bus.in0_data_wr;
    w_g_data = bus.in0_data;
    w_g_v    = bus.in0_data_valid;
    w_g_vwr  = bus.in0_data_valid_wr;
    if (r_gnt) begin
      w_g_wr   = bus.in1_data_wr;
      w_g_data = bus.in1_data;
      w_g_v    = bus.in1_data_valid;
      w_g_vwr  = bus.in1_data_valid_wr;
    end
  end

  assign w_g_type  = w_g_data[133:132];
  assign w_len_nxt = r_len + LW'(1);

  // A port holds a grant exactly while its ready is high.
  assign w_stray0 = bus.in0_data_wr & ~r_rdy0;
  assign w_stray1 = bus.in1_data_wr & ~r_rdy1;

  always_comb begin
    w_proto = 1'b0;
    if (w_g_wr) begin
      if (r_state == S_GRANT)
        w_proto = (w_g_type != T_HEAD);
      else if (r_state == S_XFER)
        w_proto = (w_g_type == T_HEAD);
    end
  end

  assign w_err_inc = {15'd0, w_stray0}
                   + {15'd0, w_stray1}
                   + {15'd0, w_proto};

  assign w_pick1 = r_req1 &
    (~r_req0 | (r_consec < CONSEC_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req0     <= 1'b0;
      r_req1     <= 1'b0;
      r_rdy0     <= 1'b0;
      r_rdy1     <= 1'b0;
      r_gnt      <= 1'b0;
      r_hold     <= 1'b0;
      r_wait     <= '0;
      r_len      <= '0;
      r_consec   <= '0;
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_v    <= 1'b0;
      r_out_vwr  <= 1'b0;
      r_pkt0     <= '0;
      r_pkt1     <= '0;
      r_abort    <= '0;
      r_err      <= '0;
    end else begin
      r_req0     <= bus.in0_req;
      r_req1     <= bus.in1_req;
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_v    <= 1'b0;
      r_out_vwr  <= 1'b0;
      r_err      <= r_err + w_err_inc;

      unique case (r_state)
        S_IDLE: begin
          // One dead cycle after every packet or revoked grant.
          if (r_hold) begin
            r_hold <= 1'b0;
          end else if (w_pick1) begin
            r_rdy1   <= 1'b1;
            r_gnt    <= 1'b1;
            r_wait   <= '0;
            r_state  <= S_GRANT;
            r_consec <= r_req0 ? r_consec + CW'(1) : '0;
          end else if (r_req0) begin
            r_rdy0   <= 1'b1;
            r_gnt    <= 1'b0;
            r_wait   <= '0;
            r_state  <= S_GRANT;
            r_consec <= '0;
          end
        end

        S_GRANT: begin
          if (w_g_wr && w_g_type == T_HEAD) begin
            r_out_wr   <= 1'b1;
            r_out_data <= w_g_data;
            r_out_v    <= w_g_v;
            r_out_vwr  <= w_g_vwr;
            r_len      <= LW'(1);
            r_state    <= S_XFER;
          end else if (r_wait == WAIT_LAST) begin
            r_rdy0  <= 1'b0;
            r_rdy1  <= 1'b0;
            r_hold  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end

        S_XFER: begin
          if (w_g_wr && w_g_type == T_HEAD) begin
            r_rdy0  <= 1'b0;
            r_rdy1  <= 1'b0;
            r_state <= S_ABORT;
          end else begin
            if (w_g_wr) begin
              r_out_wr   <= 1'b1;
              r_out_data <= w_g_data;
              r_out_v    <= w_g_v;
              r_out_vwr  <= w_g_vwr;
            end
            if (w_g_wr && w_g_type == T_TAIL) begin
              r_rdy0  <= 1'b0;
              r_rdy1  <= 1'b0;
              r_hold  <= 1'b1;
              r_state <= S_IDLE;
              if (r_gnt) r_pkt1 <= r_pkt1 + 32'd1;
              else       r_pkt0 <= r_pkt0 + 32'd1;
            end else begin
              r_len <= w_len_nxt;
              if (w_len_nxt == LEN_MAX) begin
                r_rdy0  <= 1'b0;
                r_rdy1  <= 1'b0;
                r_state <= S_ABORT;
              end
            end
          end
        end

        S_ABORT: begin
          // Forced tail marked drop so downstream discards the stub.
          r_out_wr   <= 1'b1;
          r_out_data <= {T_TAIL, 132'd0};
          r_out_v    <= 1'b0;
          r_out_vwr  <= 1'b1;
          r_abort    <= r_abort + 16'd1;
          r_hold     <= 1'b1;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in0_ready         = r_rdy0;
  assign bus.in1_ready         = r_rdy1;
  assign bus.out_data_wr       = r_out_wr;
  assign bus.out_data          = r_out_data;
  assign bus.out_data_valid    = r_out_v;
  assign bus.out_data_valid_wr = r_out_vwr;
  assign bus.port0_pkt_cnt     = r_pkt0;
  assign bus.port1_pkt_cnt     = r_pkt1;
  assign bus.abort_cnt         = r_abort;
  assign bus.err_cnt           = r_err;

endmodule

// File: tb/tb_lr_arbiter.sv
// Directed bench for lr_arbiter: grant timing, priority/starvation,
// timeout, watchdog, stray flits, protocol abort and reset.
module tb_lr_arbiter;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  lr_arbiter_if bus ();

  lr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [133:0] mk(input logic [1:0] t,
                                      input int unsigned p);
    return {t, 100'd0, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.in0_data_wr       = 1'b0;
    bus.in1_data_wr       = 1'b0;
    bus.in0_data          = '0;
    bus.in1_data          = '0;
    bus.in0_data_valid    = 1'b0;
    bus.in1_data_valid    = 1'b0;
    bus.in0_data_valid_wr = 1'b0;
    bus.in1_data_valid_wr = 1'b0;
  endtask

  task automatic drive(input bit p, input logic [133:0] d,
                       input logic vwr, input logic v);
    if (p) begin
      bus.in1_data_wr       = 1'b1;
      bus.in1_data          = d;
      bus.in1_data_valid_wr = vwr;
      bus.in1_data_valid    = v;
    end else begin
      bus.in0_data_wr       = 1'b1;
      bus.in0_data          = d;
      bus.in0_data_valid_wr = vwr;
      bus.in0_data_valid    = v;
    end
  endtask

  task automatic wait_rdy(input bit p, output int n);
    n = 0;
    while (!(p ? bus.in1_ready : bus.in0_ready) && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    clr();
    bus.in0_req = 1'b0;
    bus.in1_req = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++;
    if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready: got %b%b want 00",
               bus.in1_ready, bus.in0_ready);
    end
    n_vec++;
    if (bus.out_data_wr !== 1'b0 || bus.out_data !== '0) begin
      n_err++;
      $display("FAIL rst_out: got wr=%b data=%0h want 0",
               bus.out_data_wr, bus.out_data);
    end
    n_vec++;
    if (bus.port0_pkt_cnt !== 32'd0 || bus.port1_pkt_cnt !== 32'd0 ||
        bus.abort_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_cnt: got %0d %0d %0d %0d want 0 0 0 0",
               bus.port0_pkt_cnt, bus.port1_pkt_cnt,
               bus.abort_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_single();
    logic [133:0] f [4];
    f[0] = mk(HEAD, 32'h100);
    f[1] = mk(BODY, 32'h101);
    f[2] = mk(BODY, 32'h102);
    f[3] = mk(TAIL, 32'h103);
    bus.in0_req = 1'b1;
    tick();
    n_vec++;
    if (bus.in0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL req_early: got %b want 0", bus.in0_ready);
    end
    tick();
    n_vec++;
    if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL req_grant: got %b%b want 01",
               bus.in1_ready, bus.in0_ready);
    end
    bus.in0_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, f[i], i == 3, i == 3);
      tick();
      n_vec++;
      if (bus.out_data_wr !== 1'b1 || bus.out_data !== f[i]) begin
        n_err++;
        $display("FAIL fwd%0d: got wr=%b %0h want wr=1 %0h",
                 i, bus.out_data_wr, bus.out_data, f[i]);
      end
    end
    n_vec++;
    if (bus.out_data_valid_wr !== 1'b1 || bus.out_data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL tail_valid: got %b%b want 11",
               bus.out_data_valid_wr, bus.out_data_valid);
    end
    n_vec++;
    if (bus.in0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL tail_ready: got %b want 0", bus.in0_ready);
    end
    n_vec++;
    if (bus.port0_pkt_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL pkt0_single: got %0d want 1", bus.port0_pkt_cnt);
    end
    clr();
    tick();
    n_vec++;
    if (bus.out_data_wr !== 1'b0 || bus.out_data !== '0) begin
      n_err++;
      $display("FAIL idle_out: got wr=%b %0h want 0",
               bus.out_data_wr, bus.out_data);
    end
  endtask

  task automatic test_back_to_back();
    int exp_p [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int n;
    bit p;
    bus.in0_req = 1'b1;
    bus.in1_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (!(bus.in0_ready || bus.in1_ready) && n < 50) begin
        tick();
        n++;
      end
      n_vec++;
      if (n !== 2) begin
        n_err++;
        $display("FAIL gap%0d: got %0d cycles want 2", k, n);
      end
      n_vec++;
      if (bus.in0_ready && bus.in1_ready) begin
        n_err++;
        $display("FAIL both_ready%0d: got 11 want one-hot", k);
      end
      p = bus.in1_ready;
      n_vec++;
      if (int'(p) !== exp_p[k]) begin
        n_err++;
        $display("FAIL order%0d: got port %0d want port %0d",
                 k, p, exp_p[k]);
      end
      drive(p, mk(HEAD, 32'h200 + k), 1'b0, 1'b0);
      tick();
      clr();
      drive(p, mk(TAIL, 32'h300 + k), 1'b1, 1'b1);
      tick();
      clr();
    end
    bus.in0_req = 1'b0;
    bus.in1_req = 1'b0;
    n_vec++;
    if (bus.port0_pkt_cnt !== 32'd3 || bus.port1_pkt_cnt !== 32'd8) begin
      n_err++;
      $display("FAIL share: got p0=%0d p1=%0d want p0=3 p1=8",
               bus.port0_pkt_cnt, bus.port1_pkt_cnt);
    end
  endtask

  task automatic test_timeout();
    int n;
    tick();
    tick();
    bus.in0_req = 1'b1;
    wait_rdy(1'b0, n);
    bus.in0_req = 1'b0;
    n_vec++;
    if (n !== 2) begin
      n_err++;
      $display("FAIL to_grant: got %0d cycles want 2", n);
    end
    n = 0;
    while (bus.in0_ready && n < 40) begin
      tick();
      n++;
    end
    n_vec++;
    if (n !== 16) begin
      n_err++;
      $display("FAIL to_len: got %0d cycles want 16", n);
    end
    bus.in1_req = 1'b1;
    wait_rdy(1'b1, n);
    bus.in1_req = 1'b0;
    n_vec++;
    if (n !== 2) begin
      n_err++;
      $display("FAIL to_next: got %0d cycles want 2", n);
    end
    n = 0;
    while (bus.in1_ready && n < 40) begin
      tick();
      n++;
    end
    n_vec++;
    if (n !== 16) begin
      n_err++;
      $display("FAIL to_len1: got %0d cycles want 16", n);
    end
    n_vec++;
    if (bus.abort_cnt !== 16'd0 || bus.err_cnt !== 16'd0 ||
        bus.port1_pkt_cnt !== 32'd8) begin
      n_err++;
      $display("FAIL to_cnt: got a=%0d e=%0d p1=%0d want 0 0 8",
               bus.abort_cnt, bus.err_cnt, bus.port1_pkt_cnt);
    end
  endtask

  task automatic test_watchdog();
    int n;
    int sent;
    logic [133:0] last;
    tick();
    tick();
    bus.in1_req = 1'b1;
    wait_rdy(1'b1, n);
    bus.in1_req = 1'b0;
    n_vec++;
    if (n >= 50) begin
      n_err++;
      $display("FAIL wd_grant: got %0d cycles want <50", n);
    end
    sent = 0;
    last = '0;
    do begin
      last = mk(sent == 0 ? HEAD : BODY, 32'h400 + sent);
      drive(1'b1, last, 1'b0, 1'b0);
      tick();
      sent++;
    end while (bus.in1_ready && sent < 100);
    clr();
    n_vec++;
    if (sent !== 64) begin
      n_err++;
      $display("FAIL wd_flits: got %0d want 64", sent);
    end
    n_vec++;
    if (bus.out_data !== last) begin
      n_err++;
      $display("FAIL wd_last: got %0h want %0h", bus.out_data, last);
    end
    tick();
    n_vec++;
    if (bus.out_data_wr !== 1'b1 || bus.out_data !== mk(TAIL, 0) ||
        bus.out_data_valid !== 1'b0 || bus.out_data_valid_wr !== 1'b1) begin
      n_err++;
      $display("FAIL wd_tail: got wr=%b %0h v=%b vwr=%b want 1 %0h 0 1",
               bus.out_data_wr, bus.out_data, bus.out_data_valid,
               bus.out_data_valid_wr, mk(TAIL, 0));
    end
    n_vec++;
    if (bus.abort_cnt !== 16'd1 || bus.port1_pkt_cnt !== 32'd8) begin
      n_err++;
      $display("FAIL wd_cnt: got a=%0d p1=%0d want 1 8",
               bus.abort_cnt, bus.port1_pkt_cnt);
    end
  endtask

  task automatic test_stray();
    int n;
    logic [133:0] f [3];
    f[0] = mk(HEAD, 32'h500);
    f[1] = mk(BODY, 32'h501);
    f[2] = mk(TAIL, 32'h502);
    tick();
    tick();
    bus.in1_req = 1'b1;
    wait_rdy(1'b1, n);
    bus.in1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, f[i], i == 2, i == 2);
      drive(1'b0, mk(BODY, 32'hBAD0 + i), 1'b1, 1'b1);
      tick();
      clr();
      n_vec++;
      if (bus.out_data_wr !== 1'b1 || bus.out_data !== f[i]) begin
        n_err++;
        $display("FAIL stray_fwd%0d: got wr=%b %0h want 1 %0h",
                 i, bus.out_data_wr, bus.out_data, f[i]);
      end
    end
    drive(1'b0, mk(HEAD, 32'hBAD9), 1'b0, 1'b0);
    tick();
    clr();
    n_vec++;
    if (bus.out_data_wr !== 1'b0 || bus.out_data !== '0) begin
      n_err++;
      $display("FAIL stray_idle: got wr=%b %0h want 0",
               bus.out_data_wr, bus.out_data);
    end
    n_vec++;
    if (bus.err_cnt !== 16'd4 || bus.port1_pkt_cnt !== 32'd9) begin
      n_err++;
      $display("FAIL stray_cnt: got e=%0d p1=%0d want 4 9",
               bus.err_cnt, bus.port1_pkt_cnt);
    end
  endtask

  task automatic test_head_midpkt();
    int n;
    tick();
    tick();
    bus.in0_req = 1'b1;
    wait_rdy(1'b0, n);
    bus.in0_req = 1'b0;
    drive(1'b0, mk(HEAD, 32'h600), 1'b0, 1'b0);
    tick();
    drive(1'b0, mk(HEAD, 32'h601), 1'b0, 1'b0);
    tick();
    clr();
    n_vec++;
    if (bus.out_data_wr !== 1'b0 || bus.in0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_head: got wr=%b rdy=%b want 0 0",
               bus.out_data_wr, bus.in0_ready);
    end
    tick();
    n_vec++;
    if (bus.out_data !== mk(TAIL, 0) || bus.out_data_valid_wr !== 1'b1 ||
        bus.out_data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_abort: got %0h vwr=%b v=%b want %0h 1 0",
               bus.out_data, bus.out_data_valid_wr,
               bus.out_data_valid, mk(TAIL, 0));
    end
    n_vec++;
    if (bus.abort_cnt !== 16'd2 || bus.err_cnt !== 16'd5 ||
        bus.port0_pkt_cnt !== 32'd3) begin
      n_err++;
      $display("FAIL mid_cnt: got a=%0d e=%0d p0=%0d want 2 5 3",
               bus.abort_cnt, bus.err_cnt, bus.port0_pkt_cnt);
    end
  endtask

  task automatic test_reset_midpkt();
    int n;
    tick();
    tick();
    bus.in0_req = 1'b1;
    wait_rdy(1'b0, n);
    bus.in0_req = 1'b0;
    drive(1'b0, mk(HEAD, 32'h700), 1'b0, 1'b0);
    tick();
    drive(1'b0, mk(BODY, 32'h701), 1'b0, 1'b0);
    tick();
    drive(1'b0, mk(BODY, 32'h702), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    n_vec++;
    if (bus.out_data_wr !== 1'b0 || bus.out_data !== '0 ||
        bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mrst_out: got wr=%b %0h rdy=%b%b want 0 0 00",
               bus.out_data_wr, bus.out_data,
               bus.in1_ready, bus.in0_ready);
    end
    n_vec++;
    if (bus.port0_pkt_cnt !== 32'd0 || bus.port1_pkt_cnt !== 32'd0 ||
        bus.abort_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL mrst_cnt: got %0d %0d %0d %0d want 0 0 0 0",
               bus.port0_pkt_cnt, bus.port1_pkt_cnt,
               bus.abort_cnt, bus.err_cnt);
    end
    bus.in0_req = 1'b1;
    wait_rdy(1'b0, n);
    bus.in0_req = 1'b0;
    n_vec++;
    if (n !== 2) begin
      n_err++;
      $display("FAIL mrst_grant: got %0d cycles want 2", n);
    end
    drive(1'b0, mk(HEAD, 32'h800), 1'b0, 1'b0);
    tick();
    n_vec++;
    if (bus.out_data !== mk(HEAD, 32'h800)) begin
      n_err++;
      $display("FAIL mrst_head: got %0h want %0h",
               bus.out_data, mk(HEAD, 32'h800));
    end
    clr();
    drive(1'b0, mk(TAIL, 32'h801), 1'b1, 1'b1);
    tick();
    clr();
    n_vec++;
    if (bus.out_data !== mk(TAIL, 32'h801) ||
        bus.port0_pkt_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL mrst_tail: got %0h p0=%0d want %0h 1",
               bus.out_data, bus.port0_pkt_cnt, mk(TAIL, 32'h801));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.in0_req = 1'b0;
    bus.in1_req = 1'b0;
    clr();
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_watchdog();
    test_stray();
    test_head_midpkt();
    test_reset_midpkt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
